// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit
// Decoupled instruction-fetch front end. It owns the PC and issues requests to
// an instruction memory with one cycle of latency. Returned words go into a
// FQ_DEPTH-entry first-word-fall-through queue, and decode drains that queue
// over a valid/ready handshake. Execute-stage redirects take priority over
// everything else.
//
// Optional feature, selected by the macro RISCV_FETCH_BTFN_EN:
//   static backward-taken / forward-not-taken prediction on returned words.
//   JAL and backward B-type branches are enqueued with pred_taken=1, the
//   fall-through request of that cycle is dropped, and the PC jumps to the target.
//   With the macro undefined, fetch is purely sequential and
//   o_fetch_pred_taken is tied to 0.
module riscv_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     FQ_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [XLEN-1:0] i_imem_data,
    output logic            o_fetch_valid,
    input  logic            i_fetch_ready,
    output logic [XLEN-1:0] o_fetch_instr,
    output logic [XLEN-1:0] o_fetch_pc,
    output logic            o_fetch_pred_taken,
    input  logic            i_redirect_en,
    input  logic [XLEN-1:0] i_redirect_pc
);

    localparam int unsigned     PW        = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned     CNTW      = PW + 1;
    localparam int unsigned     OCCW      = PW + 2;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

    // PC and outstanding-request state
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_pc;
    logic            r_pending;

    // Fetch queue storage and control
    logic [XLEN-1:0] r_fq_instr [FQ_DEPTH];
    logic [XLEN-1:0] r_fq_pc    [FQ_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;

    logic            w_deq;
    logic            w_enq;
    logic            w_req;
    logic [OCCW-1:0] w_occ;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_pred_taken;
    logic [XLEN-1:0] w_pred_target;

    assign o_fetch_valid = (r_count != '0);
    assign w_deq         = o_fetch_valid & i_fetch_ready;

    // Credit rule: slots already used, plus the word in flight, minus the one
    // leaving this cycle, must leave room before a new request is issued.
    // Because of this rule the queue can never overflow.
    assign w_occ = OCCW'(r_count) + OCCW'(r_pending) - OCCW'(w_deq);

    // Gate the request with the reset input so it stays low while reset is held.
    assign w_req = i_rstn & ~i_redirect_en & (w_occ < OCCW'(FQ_DEPTH));

    // A redirect kills the response that arrives in the same cycle.
    assign w_enq = r_pending & ~i_redirect_en;

    assign w_redirect_pc = i_redirect_pc & WORD_MASK;

    assign o_imem_req    = w_req;
    assign o_imem_addr   = r_pc;
    assign o_fetch_instr = r_fq_instr[r_rd_ptr];
    assign o_fetch_pc    = r_fq_pc[r_rd_ptr];

`ifdef RISCV_FETCH_BTFN_EN
    logic [6:0]      w_opcode;
    logic            w_is_jal;
    logic            w_is_bwd_branch;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_b;
    logic            r_fq_pred [FQ_DEPTH];

    assign w_opcode        = i_imem_data[6:0];
    assign w_is_jal        = (w_opcode == 7'b1101111);
    assign w_is_bwd_branch = (w_opcode == 7'b1100011) & i_imem_data[31];
    assign w_imm_j = {{(XLEN-20){i_imem_data[31]}}, i_imem_data[19:12], i_imem_data[20],
                      i_imem_data[30:21], 1'b0};
    assign w_imm_b = {{(XLEN-12){i_imem_data[31]}}, i_imem_data[7], i_imem_data[30:25],
                      i_imem_data[11:8], 1'b0};

    // Only a response that is really enqueued may steer the PC. A redirect in
    // the same cycle already clears w_enq, so the redirect wins.
    assign w_pred_taken  = w_enq & (w_is_jal | w_is_bwd_branch);
    assign w_pred_target = (r_pend_pc + (w_is_jal ? w_imm_j : w_imm_b)) & WORD_MASK;

    assign o_fetch_pred_taken = o_fetch_valid & r_fq_pred[r_rd_ptr];

    // Store the prediction flag next to each queued word
    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_fq_pred[r_wr_ptr] <= w_pred_taken;
        end
    end
`else
    assign w_pred_taken       = 1'b0;
    assign w_pred_target      = '0;
    assign o_fetch_pred_taken = 1'b0;
`endif

    // PC sequencing. Priority order: redirect, then predicted-taken jump,
    // then sequential fetch.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_pc      <= RESET_PC;
            r_pend_pc <= RESET_PC;
            r_pending <= 1'b0;
        end else if (i_redirect_en) begin
            r_pc      <= w_redirect_pc;
            r_pending <= 1'b0;
        end else if (w_pred_taken) begin
            // The fall-through request issued this cycle is dropped here.
            r_pc      <= w_pred_target;
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_req;
            if (w_req) begin
                r_pc      <= r_pc + PC_STEP;
                r_pend_pc <= r_pc;
            end
        end
    end

    // Queue pointers and occupancy; a redirect flushes the queue after any head handshake
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_redirect_en) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CNTW'(w_enq) - CNTW'(w_deq);
        end
    end

    // Queue payload: the instruction word and its fetch address
    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_fq_instr[r_wr_ptr] <= i_imem_data;
            r_fq_pc[r_wr_ptr]    <= r_pend_pc;
        end
    end

endmodule
